// File: rtl/spi_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_bridge
//
// SPI mode-0 slave that bridges an external SPI master into the clk domain.
// sclk, cs_n and mosi are asynchronous. Each one passes through a
// SYNC_STAGES-deep synchronizer. All of the protocol logic then runs on
// posedge clk, using edges found in the synchronized signals.
//
// Receive : mosi is sampled on every sclk rising edge, MSB first. When the
//           eighth bit arrives, data_rx is updated and byte_sync pulses.
// Transmit: tx_shift is loaded from data_tx when cs_n falls. It is loaded
//           again TX_LOAD_DLY cycles after each byte_sync, and shifts on sclk
//           falling edges. miso is a registered copy of tx_shift[7].
//
// Parameters
//   SYNC_STAGES  synchronizer depth for sclk / cs_n / mosi (2..3)
//   TX_LOAD_DLY  clk cycles from byte_sync to the tx reload (1..3)
//
// Ports
//   clk        peripheral clock
//   rst_n      asynchronous active-low reset
//   sclk       SPI serial clock from the master (async)
//   cs_n       SPI chip select, active-low (async)
//   mosi       SPI master-out data (async)
//   miso       SPI master-in data (registered)
//   byte_sync  one-clk pulse: data_rx holds a freshly received byte
//   data_rx    last complete received byte
//   data_tx    byte to transmit; sampled only at load points
//   frame_err  one-clk pulse: cs_n deasserted in the middle of a byte
// -----------------------------------------------------------------------------
module spi_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TX_LOAD_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_rx,
    input  logic [7:0] data_tx,
    output logic       frame_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // After reset the synchronizers need this many cycles before cs_n can be
    // trusted. Only after that do we check whether cs_n is really high.
    localparam logic [2:0] FLUSH_LAST = 3'(SYNC_STAGES + 1);
    localparam logic [1:0] LOAD_START = 2'(TX_LOAD_DLY);

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments, so every flop in
    // the chain samples the value it had before the edge. With blocking
    // assignments a multi-stage synchronizer would collapse into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // ------------------------------------------------------------------
    // Arming after reset
    // The synchronizers reset to "cs_n high". If cs_n is already low when
    // reset is released, the pipeline shows a falling edge that is not real.
    // A frame can only start once cs_n has been seen high after the flush.
    // ------------------------------------------------------------------
    logic [2:0] flush_cnt;
    logic       armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_LAST) begin
                flush_cnt <= flush_cnt + 3'd1;
            end
            if (flush_cnt == FLUSH_LAST && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: IDLE while cs_n is high, ACTIVE while a frame is in progress
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default value first.
    // A path that does not assign it would otherwise imply a latch.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (cs_fall && armed) state_next = ACTIVE;
            ACTIVE:  if (cs_rise)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_next;
    logic [1:0] load_cnt;

    logic active;
    logic start;
    logic leave;
    logic bit_rise;
    logic byte_done;
    logic tx_reload;

    assign active    = (state_q == ACTIVE);
    assign start     = (state_q == IDLE) && (state_next == ACTIVE);
    assign leave     = active && cs_rise;
    assign bit_rise  = active && sclk_rise;
    // A byte that completes on the same cycle that cs_n rises still counts.
    assign byte_done = bit_rise && (bit_cnt == 3'd7);
    assign tx_reload = active && (load_cnt == 2'd1);

    // Transmit shifter next value. A load wins over a shift. After the eighth
    // bit bit_cnt is 0, so the falling edge that follows it leaves the freshly
    // reloaded byte in place.
    always_comb begin
        tx_next = tx_shift;
        if (start || tx_reload) begin
            tx_next = data_tx;
        end else if (active && sclk_fall && (bit_cnt != 3'd0)) begin
            tx_next = {tx_shift[6:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Receive path, status pulses and tx reload timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            data_rx   <= '0;
            byte_sync <= 1'b0;
            frame_err <= 1'b0;
            load_cnt  <= '0;
        end else begin
            byte_sync <= byte_done;
            frame_err <= leave && (bit_cnt != 3'd0) && !byte_done;

            if (start || leave) begin
                bit_cnt <= '0;
            end else if (bit_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // A partial byte is dropped when the frame ends.
            if (leave) begin
                rx_shift <= '0;
            end else if (bit_rise) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
            end

            if (byte_done) begin
                data_rx <= {rx_shift[6:0], mosi_s};
            end

            // The counter is armed together with byte_sync. It reaches 1 on
            // the cycle whose closing edge reloads tx_shift, which is exactly
            // TX_LOAD_DLY cycles after the byte_sync pulse. Entering IDLE
            // cancels any reload that is still pending.
            if (state_next == IDLE) begin
                load_cnt <= '0;
            end else if (byte_done) begin
                load_cnt <= LOAD_START;
            end else if (load_cnt != 2'd0) begin
                load_cnt <= load_cnt - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path. miso is driven from the next-state value, so the
    // registered pin always matches tx_shift[7] in ACTIVE and is 0 in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            miso     <= 1'b0;
        end else begin
            tx_shift <= tx_next;
            miso     <= (state_next == ACTIVE) ? tx_next[7] : 1'b0;
        end
    end

endmodule

// File: doc/spi_bridge.md
SPI_BRIDGE -- requirements
Module: spi_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer (sclk, cs_n, mosi); legal range 2..3.
REQ-002 Parameter TX_LOAD_DLY, default 2: clk cycles from byte_sync to the transmit-shifter load; legal range 1..3.
REQ-003 clk  input  1  peripheral clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select from master, active-low, asynchronous to clk.
REQ-007 mosi  input  1  SPI master-out data, asynchronous to clk.
REQ-008 miso  output  1  SPI master-in data; registered.
REQ-009 byte_sync  output  1  one-clk pulse marking a complete received byte on data_rx.
REQ-010 data_rx  output  8  last received byte; held stable until the next byte completes.
REQ-011 data_tx  input  8  byte to shift out; sampled at load points only.
REQ-012 frame_err  output  1  one-clk pulse when cs_n deasserts mid-byte.

Function
REQ-013 SPI mode 0 SHALL be used: sample mosi on sclk rising edge, update miso on sclk falling edge, MSB first, 8-bit words.
REQ-014 sclk, cs_n and mosi SHALL each pass through a SYNC_STAGES flip-flop synchronizer; edges are detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-015 The master's sclk high and low phases SHALL each be at least SYNC_STAGES+2 clk periods; behaviour is undefined for faster sclk.
REQ-016 The FSM SHALL have two states: IDLE (synchronized cs_n high) and ACTIVE (synchronized cs_n low).
REQ-017 IDLE->ACTIVE on the synchronized cs_n falling edge: bit_cnt is cleared, and the tx shifter is loaded with data_tx in that same cycle.
REQ-018 In ACTIVE, each synchronized sclk rising edge SHALL shift the synchronized mosi into rx_shift[0] and increment the 3-bit bit_cnt.
REQ-019 On the rising edge that wraps bit_cnt from 7 to 0, data_rx SHALL take the assembled byte and byte_sync SHALL pulse high in the following clk cycle, for exactly one cycle.
REQ-020 In ACTIVE, a synchronized sclk falling edge SHALL shift tx_shift left by one only when bit_cnt != 0; the falling edge that follows bit 7 is ignored.
REQ-021 The tx shifter SHALL reload from data_tx exactly TX_LOAD_DLY cycles after each byte_sync pulse, which allows the downstream read response to settle.
REQ-022 miso SHALL equal tx_shift[7] while in ACTIVE and 0 while in IDLE.
REQ-023 ACTIVE->IDLE on the synchronized cs_n rising edge: if bit_cnt != 0, the partial byte is discarded, no byte_sync is generated, and frame_err pulses for one cycle; bit_cnt clears in all cases.
REQ-024 If a cs_n rising edge coincides with the rising edge that completes byte 8, the byte SHALL be delivered (byte_sync pulses) and frame_err SHALL NOT pulse.
REQ-025 A pending TX_LOAD_DLY reload SHALL be cancelled when the FSM enters IDLE.
REQ-026 sclk edges seen in IDLE SHALL have no effect on any state.
REQ-027 Consecutive bytes within one cs_n frame SHALL be handled back-to-back with no limit on frame length.

Reset
REQ-028 While rst_n is low: FSM=IDLE; bit_cnt, rx_shift, tx_shift and data_rx =0; byte_sync, frame_err and miso =0; synchronizer flops = cs_n high, sclk low, mosi low.
REQ-029 Reset asserted mid-byte SHALL abort the transfer immediately; after release, the block waits in IDLE for a fresh cs_n falling edge, even if cs_n is already low.

Verification
REQ-030 Frame cs_n low, master sends 0x85 then 0xA5 -> byte_sync pulses twice; data_rx = 0x85 then 0xA5; frame_err never pulses.
REQ-031 data_tx = 0x3C held before cs_n falls, master clocks 8 bits -> master samples 0x3C on miso.
REQ-032 First byte 0x05 (read), data_tx changes to 0xC3 one cycle after byte_sync -> second byte on miso reads 0xC3.
REQ-033 cs_n rises after 5 bits of 0xFF -> frame_err pulses once, no byte_sync, data_rx unchanged; next full frame with 0x12 gives data_rx = 0x12.
REQ-034 rst_n pulsed low after 3 bits with cs_n held low -> all outputs 0; further sclk edges produce no byte_sync until cs_n toggles high then low.
REQ-035 cs_n rising edge in the same clk cycle as the 8th sclk rising edge of 0x7E -> byte_sync pulses with data_rx = 0x7E, and frame_err stays 0.
